// File: rtl/div_34by17_seq_if.sv
// Request/response bundle for the sequential 2W/W restoring divider.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface div_34by17_seq_if #(
  parameter int W = 17
);
  localparam int DW = 2 * W;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_34by17_seq.sv
// Sequential restoring divider: 2W-bit unsigned dividend / W-bit divisor, one quotient bit
// per clock. Used to reduce 34-bit limb products back to a 17-bit residue.
module div_34by17_seq #(
  parameter int W = 17
) (
  input  logic                   clk,
  input  logic                   reset_n,
  div_34by17_seq_if.slave        bus,
  output logic [1:0]             dbg_state
);
  localparam int DW = 2 * W;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [DW-1:0]  sr;
  logic [W-1:0]   pr;
  logic [W-1:0]   dvs;
  logic [CW-1:0]  cnt;
  logic [DW-1:0]  quotient_r;
  logic [W-1:0]   remainder_r;
  logic           dbz_r;

  logic           accept;
  logic           zero_dvs;
  logic [W:0]     t;
  logic           q_bit;
  logic [W-1:0]   pr_nxt;

  assign accept   = bus.in_valid && (state == IDLE);
  assign zero_dvs = (bus.divisor == '0);

  // Compare at W+1 bits so t up to 2*divisor-1 is handled; when the subtraction is taken
  // the difference is < divisor, so its low W bits are exact.
  always_comb begin
    t      = {pr, sr[DW-1]};
    q_bit  = (t >= {1'b0, dvs});
    pr_nxt = q_bit ? (t[W-1:0] - dvs) : t[W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = zero_dvs ? DONE : BUSY;
      BUSY: if (cnt == '0) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    dbg_state     = state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr          <= '0;
      pr          <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (zero_dvs) begin
              quotient_r  <= '1;
              remainder_r <= bus.dividend[W-1:0];
              dbz_r       <= 1'b1;
            end else begin
              dvs   <= bus.divisor;
              sr    <= bus.dividend;
              pr    <= '0;
              cnt   <= CW'(DW - 1);
              dbz_r <= 1'b0;
            end
          end
        end
        BUSY: begin
          sr  <= {sr[DW-2:0], q_bit};
          pr  <= pr_nxt;
          cnt <= cnt - 1'b1;
          // Result registers are separate so they hold after handoff until the next result.
          if (cnt == '0) begin
            quotient_r  <= {sr[DW-2:0], q_bit};
            remainder_r <= pr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: doc/div_34by17_seq.md
Name: div_34by17_seq

Overview:
- Sequential restoring divider: unsigned 2W-bit dividend (default 34) divided by W-bit divisor (default 17); returns quotient and remainder.
- Inverse of the 17x17 DSP product path in the modular-square datapath.
- Used to check and reduce partial products: takes a 34-bit product, returns quotient and residue modulo a 17-bit limb.
- One quotient bit per clock; valid/ready handshake on both sides.

Parameters:
- W, 17, divisor and remainder width.
- DW, 2*W, dividend and quotient width. Derived; must not be overridden independently.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  dividend/divisor presented
- in_ready  output  1  block can accept an operation
- dividend  input  DW  unsigned dividend
- divisor  input  W  unsigned divisor
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- quotient  output  DW  unsigned quotient
- remainder  output  W  unsigned remainder
- div_by_zero  output  1  result came from a zero divisor

Behaviour:
- Reset (async assert, sync release internally irrelevant; outputs take values immediately):
  - state=IDLE; in_ready=1; out_valid=0.
  - quotient, remainder, div_by_zero all 0; internal bit counter 0.
- States: IDLE, BUSY, DONE.
- in_ready=1 only in IDLE.
- out_valid=1 only in DONE.
- IDLE -> BUSY when in_valid&&in_ready and divisor!=0.
  - Latch divisor; shift register <= dividend; partial remainder (W+1 bits) <= 0; counter <= DW-1.
- IDLE -> DONE when in_valid&&in_ready and divisor==0.
  - Next cycle: quotient = all ones (2^DW-1); remainder = dividend[W-1:0]; div_by_zero=1.
- BUSY, each cycle:
  - t = {pr[W-1:0], msb of shift reg}.
  - If t >= divisor: pr = t - divisor and quotient bit = 1; else pr = t and quotient bit = 0.
  - Quotient bit shifts into the LSB of the shift register.
  - Counter decrements.
  - When the counter is 0 that cycle, go to DONE.
- Latency: accept edge to out_valid high is exactly DW cycles (34) for nonzero divisor; 1 cycle for zero divisor.
- DONE:
  - quotient, remainder and div_by_zero are stable while out_valid=1.
  - They remain valid until out_valid&&out_ready. Then go to IDLE; out_valid drops the next cycle.
  - quotient/remainder hold their last values after handoff; div_by_zero clears on the next accept.
- in_ready=0 during BUSY/DONE. in_valid during those states is ignored; the source must hold it.
- Throughput: one operation per DW+2 cycles minimum, with out_ready held high.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
- reset_n asserted mid-operation: in-flight operation discarded, reset values restored; no result produced.
- Arithmetic: unsigned only.
  - Remainder always < divisor when divisor != 0.
  - quotient*divisor + remainder == dividend exactly.
  - Subtraction uses W+1 bits so t up to 2*divisor-1 is handled.
- Dividend 0 with nonzero divisor: quotient 0, remainder 0, full DW latency.
- Divisor 1: quotient = dividend, remainder 0.

Test Plan:
- After reset: dividend=100, divisor=7, out_ready=1 -> out_valid exactly 34 cycles after accept; quotient=14, remainder=2, div_by_zero=0.
- dividend=0x3FFFC0001 (0x1FFFF squared), divisor=0x1FFFF -> quotient=0x1FFFF, remainder=0.
- dividend=0x3FFFFFFFF, divisor=1 -> quotient=0x3FFFFFFFF, remainder=0.
- dividend=0x3FFFFFFFF, divisor=0x10000 -> quotient=0x3FFFF, remainder=0xFFFF.
- divisor=0, dividend=0x12345 -> out_valid one cycle after accept; quotient=0x3FFFFFFFF, remainder=0x12345, div_by_zero=1.
- Backpressure:
  - out_ready=0 for 10 cycles in DONE -> out_valid and outputs hold, in_ready stays 0.
  - Then out_ready=1 -> in_ready=1 the next cycle.
  - Back-to-back ops (100/7 then 1000/13) -> results 14 r2, then 76 r12.
- Reset mid-op: reset_n low at cycle 10 of BUSY -> out_valid=0, in_ready=1, outputs 0 immediately.
  - After release, 50/6 -> quotient=8, remainder=2.
- Randomized: 10k random (dividend, divisor!=0) pairs -> quotient*divisor+remainder == dividend and remainder < divisor.
